// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder (tx) and the Viterbi decoder (rx):
// code polynomials, trellis size, code symbol type and encoder FSM states.
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int NUM_STATES = 2**(K-1);

  typedef logic [1:0] code_sym_t;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    FLUSH,
    DONE
  } enc_state_t;

endpackage

// File: rtl/conv_parity.sv
// Combinational parity stage: maps the encoder window s = {bit, sr} to the
// code symbol {parity(G0), parity(G1)}.
module conv_parity
  import viterbi_pkg::code_sym_t;
#(
  parameter int           K  = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic [K-1:0] s,
  output code_sym_t    sym
);

  always_comb begin
    sym = {^(s & G0), ^(s & G1)};
  end

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder, transmit side: accepts FRAME_LEN bits, appends
// K-1 zero tail bits and streams one registered code symbol per bit.
module conv_encoder_tx #(
  parameter int           K         = viterbi_pkg::K,
  parameter logic [K-1:0] G0        = viterbi_pkg::G0,
  parameter logic [K-1:0] G1        = viterbi_pkg::G1,
  parameter int           FRAME_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic       i_bit,
  output logic       o_ready,
  output logic       o_valid,
  output logic [1:0] o_data,
  output logic       o_last,
  input  logic       i_ready,
  output logic       o_busy
);

  import viterbi_pkg::code_sym_t;
  import viterbi_pkg::enc_state_t;
  import viterbi_pkg::IDLE;
  import viterbi_pkg::ENC;
  import viterbi_pkg::FLUSH;
  import viterbi_pkg::DONE;

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  enc_state_t    state;
  enc_state_t    state_nxt;
  logic [K-2:0]  sr;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] tail_cnt;

  logic          slot_free;
  logic          accept;
  logic          tail_fire;
  logic          load;
  logic          last_sym;
  logic          enc_bit;
  logic [K-1:0]  s;
  code_sym_t     sym;

  conv_parity #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_parity (
    .s   (s),
    .sym (sym)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ENC;
      ENC:     if (accept && (bit_cnt == LAST_BIT)) state_nxt = FLUSH;
      FLUSH:   if (last_sym) state_nxt = DONE;
      DONE:    if (o_valid && i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode; the output slot frees in the same cycle the
  // downstream takes the symbol, so streaming has no bubbles.
  always_comb begin
    slot_free = !o_valid || i_ready;
    o_ready   = (state == ENC) && slot_free;
    accept    = o_ready && i_valid;
    tail_fire = (state == FLUSH) && slot_free;
    load      = accept || tail_fire;
    last_sym  = tail_fire && (tail_cnt == LAST_TAIL);
    enc_bit   = (state == ENC) ? i_bit : 1'b0;
    s         = {enc_bit, sr};
    o_busy    = (state != IDLE);
  end

  // Shift register and frame counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      tail_cnt <= '0;
    end else if ((state == IDLE) && i_start) begin
      sr       <= '0;
      bit_cnt  <= '0;
      tail_cnt <= '0;
    end else if (load) begin
      sr <= s[K-1:1];
      if (accept) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (tail_fire) begin
        tail_cnt <= tail_cnt + 1'b1;
      end
    end
  end

  // One-entry output register; contents hold while stalled by i_ready=0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= sym;
      o_last  <= last_sym;
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: directed and randomized frames
// checked against a polynomial-form reference model of the K=3 (7,5) code.
module tb_conv_encoder_tx;

  typedef bit bit_q_t[$];
  typedef logic [2:0] sym_q_t[$];   // {last, data[1], data[0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       bitv = 1'b0;
  logic       iready = 1'b1;
  logic       ready_o, ovalid, olast, busy;
  logic [1:0] odata;

  logic       start1 = 1'b0;
  logic       valid1 = 1'b0;
  logic       bit1 = 1'b0;
  logic       iready1 = 1'b1;
  logic       ready1, ovalid1, olast1, busy1;
  logic [1:0] odata1;

  conv_encoder_tx #(
    .K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_bit(bitv),
    .o_ready(ready_o), .o_valid(ovalid), .o_data(odata), .o_last(olast),
    .i_ready(iready), .o_busy(busy)
  );

  conv_encoder_tx #(
    .K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_valid(valid1), .i_bit(bit1),
    .o_ready(ready1), .o_valid(ovalid1), .o_data(odata1), .o_last(olast1),
    .i_ready(iready1), .o_busy(busy1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int timeouts = 0;

  // Monitor-owned observations
  sym_q_t     got_q;
  int         hold_viol = 0;
  int         stall_cycles = 0;
  int         ready_in_flush = 0;
  logic       prev_stall = 1'b0;
  logic [2:0] prev_sym = '0;
  logic       all_sent = 1'b0;

  // Downstream ready generator
  int ready_mode = 0;
  int stall_at = -1;
  int stall_target = 0;
  int stall_done = 0;

  // Reference model: d1 = b[n]^b[n-1]^b[n-2], d0 = b[n]^b[n-2], two zero tail bits.
  function automatic sym_q_t model(input bit_q_t bits);
    sym_q_t r;
    bit_q_t h;
    bit m1, m2;
    h = bits;
    h.push_back(1'b0);
    h.push_back(1'b0);
    for (int n = 0; n < h.size(); n++) begin
      m1 = (n >= 1) ? h[n-1] : 1'b0;
      m2 = (n >= 2) ? h[n-2] : 1'b0;
      r.push_back({(n == h.size() - 1), h[n] ^ m1 ^ m2, h[n] ^ m2});
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!ovalid || ({olast, odata} !== prev_sym))) hold_viol++;
      prev_stall = ovalid && !iready;
      prev_sym   = {olast, odata};
      if (ovalid && !iready) stall_cycles++;
      if (all_sent && ready_o) ready_in_flush++;
      if (ovalid && iready) got_q.push_back({olast, odata});
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: iready = 1'b1;
      1: iready = 1'($urandom_range(0, 1));
      default: begin
        if (ovalid && (got_q.size() == stall_at) && (stall_done < stall_target)) begin
          iready = 1'b0;
          stall_done++;
        end else begin
          iready = 1'b1;
        end
      end
    endcase
  end

  task automatic send_bit(input logic b, input logic with_start);
    valid = 1'b1;
    bitv  = b;
    start = with_start;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk);
        #1;
        valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    timeouts++;
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_frame(input bit_q_t bits, input int gap_max, input int start_at,
                           output sym_q_t got, output logic busy_last);
    int base;
    bit done;
    base = got_q.size();
    got = {};
    done = 1'b0;
    busy_last = 1'bx;
    all_sent = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    foreach (bits[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
      send_bit(bits[i], (i == start_at));
    end
    all_sent = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk); #1;
      if ((got_q.size() > base) && got_q[got_q.size()-1][2]) begin
        done = 1'b1;
        busy_last = busy;
      end
    end
    if (!done) timeouts++;
    @(posedge clk); #1;
    all_sent = 1'b0;
    for (int i = base; i < got_q.size(); i++) got.push_back(got_q[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ovalid, odata, olast, ready_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 00000", {ovalid, odata, olast, ready_o});
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins_busy got %b want 0", busy);
    end
    n_checks++;
    if ({ovalid1, odata1, olast1, ready1, busy1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_len1 got %b want 000000", {ovalid1, odata1, olast1, ready1, busy1});
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic;
    sym_q_t got, exp;
    logic bl;
    ready_mode = 0;
    exp = {3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    run_frame({1'b1, 1'b0, 1'b1, 1'b1}, 0, -1, got, bl);
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL basic_len got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_sym[%0d] got %b want %b", i, got[i], exp[i]);
      end
    end
    n_checks++;
    if (bl !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_at_last got %b want 1", bl);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after got %b want 0", busy);
    end
  endtask

  task automatic test_stall;
    sym_q_t got, exp;
    logic bl;
    int h0, s0;
    h0 = hold_viol;
    s0 = stall_cycles;
    stall_at = got_q.size() + 1;
    stall_target = stall_done + 3;
    ready_mode = 2;
    exp = {3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    run_frame({1'b1, 1'b0, 1'b1, 1'b1}, 0, -1, got, bl);
    ready_mode = 0;
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL stall_len got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL stall_sym[%0d] got %b want %b", i, got[i], exp[i]);
      end
    end
    n_checks++;
    if (stall_cycles - s0 !== 3) begin
      n_fail++;
      $display("FAIL stall_cycles got %0d want 3", stall_cycles - s0);
    end
    n_checks++;
    if (hold_viol - h0 !== 0) begin
      n_fail++;
      $display("FAIL stall_hold got %0d violations want 0", hold_viol - h0);
    end
  endtask

  task automatic test_valid_gaps;
    sym_q_t got, exp;
    logic bl;
    int r0;
    r0 = ready_in_flush;
    ready_mode = 0;
    exp = {3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    run_frame({1'b1, 1'b0, 1'b1, 1'b1}, 4, -1, got, bl);
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL gaps_len got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL gaps_sym[%0d] got %b want %b", i, got[i], exp[i]);
      end
    end
    n_checks++;
    if (ready_in_flush - r0 !== 0) begin
      n_fail++;
      $display("FAIL flush_ready got %0d cycles with o_ready=1 want 0", ready_in_flush - r0);
    end
  endtask

  task automatic test_all_zero;
    sym_q_t got;
    logic bl;
    ready_mode = 1;
    run_frame({1'b0, 1'b0, 1'b0, 1'b0}, 1, -1, got, bl);
    ready_mode = 0;
    n_checks++;
    if (got.size() !== 6) begin
      n_fail++;
      $display("FAIL zero_len got %0d want 6", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== ((i == 5) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL zero_sym[%0d] got %b want %b", i, got[i], (i == 5) ? 3'b100 : 3'b000);
      end
    end
    n_checks++;
    if (dut.sr !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_sr_end got %b want 00", dut.sr);
    end
  endtask

  task automatic test_reset_mid;
    sym_q_t got, exp;
    bit_q_t bq;
    logic bl;
    int base;
    int lasts;
    ready_mode = 0;
    base = got_q.size();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ovalid, odata, olast, ready_o, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %b want 000000", {ovalid, odata, olast, ready_o, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    lasts = 0;
    for (int i = base; i < got_q.size(); i++) if (got_q[i][2]) lasts++;
    n_checks++;
    if (lasts !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_last got %0d last symbols want 0", lasts);
    end
    for (int j = 0; j < 4; j++) bq.push_back(bit'($urandom_range(0, 1)));
    exp = model(bq);
    run_frame(bq, 1, -1, got, bl);
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL midreset_fresh_len got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL midreset_fresh_sym[%0d] got %b want %b", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_start_in_enc;
    sym_q_t got, exp;
    bit_q_t bq;
    logic bl;
    ready_mode = 0;
    for (int j = 0; j < 4; j++) bq.push_back(bit'($urandom_range(0, 1)));
    exp = model(bq);
    run_frame(bq, 0, 2, got, bl);
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL start_in_enc_len got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL start_in_enc_sym[%0d] got %b want %b", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    sym_q_t got, exp;
    bit_q_t bq;
    logic bl;
    int h0;
    h0 = hold_viol;
    ready_mode = 1;
    for (int f = 0; f < 20; f++) begin
      bq = {};
      for (int j = 0; j < 4; j++) bq.push_back(bit'($urandom_range(0, 1)));
      exp = model(bq);
      run_frame(bq, (f % 3), -1, got, bl);
      n_checks++;
      if (got.size() !== exp.size()) begin
        n_fail++;
        $display("FAIL b2b_len frame %0d got %0d want %0d", f, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL b2b_sym frame %0d [%0d] got %b want %b", f, i, got[i], exp[i]);
        end
      end
    end
    ready_mode = 0;
    n_checks++;
    if (hold_viol - h0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold got %0d violations want 0", hold_viol - h0);
    end
  endtask

  task automatic test_frame_len_one;
    sym_q_t got, exp;
    bit_q_t bq;
    bit accepted;
    for (int f = 0; f < 2; f++) begin
      bq = {bit'(f)};
      exp = model(bq);
      got = {};
      accepted = 1'b0;
      @(posedge clk); #1; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      valid1 = 1'b1;
      bit1 = bq[0];
      for (int c = 0; c < 20 && !accepted; c++) begin
        @(negedge clk);
        if (ready1) begin
          accepted = 1'b1;
          @(posedge clk); #1;
        end
      end
      valid1 = 1'b0;
      if (!accepted) timeouts++;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (ovalid1) got.push_back({olast1, odata1});
        if (ovalid1 && olast1) break;
      end
      n_checks++;
      if (got.size() !== exp.size()) begin
        n_fail++;
        $display("FAIL len1_len bit %0d got %0d want %0d", f, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL len1_sym bit %0d [%0d] got %b want %b", f, i, got[i], exp[i]);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_busy_after got %b want 0", busy1);
    end
  endtask

  task automatic test_timeouts;
    n_checks++;
    if (timeouts !== 0) begin
      n_fail++;
      $display("FAIL handshake_timeouts got %0d want 0", timeouts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_valid_gaps();
    test_all_zero();
    test_reset_mid();
    test_start_in_enc();
    test_back_to_back();
    test_frame_len_one();
    test_timeouts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
